pacman_mover: RTL and testbench

//  Parametrised sprite movement engine for Pac-Man and, with per-instance parameters, ghosts. Replaces the per-frame keycode-only mover.

---
 rtl/pacman_pkg.sv | 34 +++
 rtl/pacman_mover_turn_buffer.sv | 52 +++++
 rtl/pacman_mover.sv | 193 +++++++++++++++++++
 tb/tb_pacman_mover.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared types and keycode constants for the sprite mover
package pacman_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_LEFT,
        DIR_RIGHT,
        DIR_UP,
        DIR_DOWN
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        Q_PEND,
        Q_CUR,
        MOVE
    } mover_state_t;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_UP    = 8'h1A;

    function automatic dir_t key_to_dir(input logic [7:0] key);
        case (key)
            KEY_LEFT:  return DIR_LEFT;
            KEY_RIGHT: return DIR_RIGHT;
            KEY_DOWN:  return DIR_DOWN;
            KEY_UP:    return DIR_UP;
            default:   return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/pacman_mover_turn_buffer.sv
// rtl/pacman_mover_turn_buffer.sv - latches a pre-turn request that expires after PEND_FRAMES frames
module turn_buffer
    import pacman_pkg::*;
#(
    parameter int PEND_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic       clear,
    output dir_t       pend_dir
);

    localparam int AW = $clog2(PEND_FRAMES + 1);

    dir_t          pend_dir_q, pend_dir_d;
    logic [AW-1:0] age_q, age_d;
    dir_t          key_dir;

    always_comb begin
        key_dir    = key_to_dir(keycode);
        pend_dir_d = pend_dir_q;
        age_d      = age_q;
        // a fresh key re-arms the request even on a tick or an accepted turn
        if (key_dir != DIR_NONE) begin
            pend_dir_d = key_dir;
            age_d      = AW'(PEND_FRAMES);
        end else if (clear) begin
            pend_dir_d = DIR_NONE;
            age_d      = '0;
        end else if (frame_tick && (age_q != '0)) begin
            age_d = age_q - 1'b1;
            if (age_q == AW'(1)) begin
                pend_dir_d = DIR_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_dir_q <= DIR_NONE;
            age_q      <= '0;
        end else begin
            pend_dir_q <= pend_dir_d;
            age_q      <= age_d;
        end
    end

    assign pend_dir = pend_dir_q;

endmodule

// File: rtl/pacman_mover.sv
// rtl/pacman_mover.sv - sprite mover: wall-probed turns, gliding, border clamp and side tunnel
module pacman_mover
    import pacman_pkg::*;
#(
    parameter int X_CENTER    = 202,
    parameter int Y_CENTER    = 253,
    parameter int X_MIN       = 7,
    parameter int X_MAX       = 396,
    parameter int Y_MIN       = 7,
    parameter int Y_MAX       = 440,
    parameter int SIZE        = 13,
    parameter int STEP        = 1,
    parameter int PEND_FRAMES = 8,
    parameter int ACK_TIMEOUT = 15,
    parameter int TUNNEL_EN   = 1,
    parameter int TUNNEL_Y    = 253
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    output logic       wall_req,
    output logic [9:0] wall_qx,
    output logic [9:0] wall_qy,
    input  logic       wall_ack,
    input  logic       wall_hit,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] BallS,
    output logic [3:0] last_dirX,
    output logic [3:0] last_dirY,
    output logic       moving,
    output logic       overrun
);

    localparam int            TW     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [9:0]    SZ     = 10'(SIZE);
    localparam logic [9:0]    ST     = 10'(STEP);
    localparam logic [9:0]    X_LO   = 10'(X_MIN + SIZE);
    localparam logic [9:0]    X_HI   = 10'(X_MAX - SIZE);
    localparam logic [9:0]    Y_LO   = 10'(Y_MIN + SIZE);
    localparam logic [9:0]    Y_HI   = 10'(Y_MAX - SIZE);

    mover_state_t  state_q, state_d;
    dir_t          cur_q, cur_d, try_q, try_d, pend_dir, probe_dir;
    logic [9:0]    x_q, x_d, y_q, y_d, qx_q, qx_d, qy_q, qy_d;
    logic [3:0]    ldx_q, ldx_d, ldy_q, ldy_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          req_q, req_d, overrun_q, overrun_d, clear;
    logic          resp_valid, resp_hit, tunnel_row;

    turn_buffer #(.PEND_FRAMES(PEND_FRAMES)) u_turn_buffer (
        .clk       (Clk),
        .reset     (Reset),
        .frame_tick(frame_tick),
        .keycode   (keycode),
        .clear     (clear),
        .pend_dir  (pend_dir)
    );

    // an unanswered probe is resolved as a wall once the timeout elapses
    assign resp_valid = wall_ack || (timer_q == T_LAST);
    assign resp_hit   = wall_hit || !wall_ack;
    assign tunnel_row = (TUNNEL_EN != 0) && (y_q == 10'(TUNNEL_Y));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cur_q     <= DIR_NONE;
            try_q     <= DIR_NONE;
            x_q       <= 10'(X_CENTER);
            y_q       <= 10'(Y_CENTER);
            qx_q      <= '0;
            qy_q      <= '0;
            ldx_q     <= '0;
            ldy_q     <= '0;
            timer_q   <= '0;
            req_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            try_q     <= try_d;
            x_q       <= x_d;
            y_q       <= y_d;
            qx_q      <= qx_d;
            qy_q      <= qy_d;
            ldx_q     <= ldx_d;
            ldy_q     <= ldy_d;
            timer_q   <= timer_d;
            req_q     <= req_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (frame_tick) begin
                if ((pend_dir != DIR_NONE) && (pend_dir != cur_q)) state_d = Q_PEND;
                else if (cur_q != DIR_NONE)                       state_d = Q_CUR;
            end
            Q_PEND: if (resp_valid) begin
                if (!resp_hit)               state_d = MOVE;
                else if (cur_q != DIR_NONE)  state_d = Q_CUR;
                else                         state_d = IDLE;
            end
            Q_CUR: if (resp_valid) state_d = resp_hit ? IDLE : MOVE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_d     = cur_q;
        try_d     = try_q;
        x_d       = x_q;
        y_d       = y_q;
        qx_d      = qx_q;
        qy_d      = qy_q;
        ldx_d     = ldx_q;
        ldy_d     = ldy_q;
        clear     = 1'b0;
        req_d     = (state_d == Q_PEND) || (state_d == Q_CUR);
        timer_d   = ((state_d != state_q) || !req_q) ? '0 : timer_q + 1'b1;
        overrun_d = frame_tick && (state_q != IDLE);
        probe_dir = (state_d == Q_PEND) ? pend_dir : cur_q;

        // probe point is captured once per Q_ state so it stays stable under wall_req
        if (req_d && (state_d != state_q)) begin
            try_d = probe_dir;
            qx_d  = x_q;
            qy_d  = y_q;
            case (probe_dir)
                DIR_LEFT:  qx_d = x_q - SZ - ST;
                DIR_RIGHT: qx_d = x_q + SZ + ST;
                DIR_UP:    qy_d = y_q - SZ - ST;
                DIR_DOWN:  qy_d = y_q + SZ + ST;
                default:   ;
            endcase
        end

        case (state_q)
            Q_PEND: if (resp_valid && !resp_hit) begin
                cur_d = try_q;
                clear = 1'b1;
            end
            Q_CUR: if (resp_valid && resp_hit) cur_d = DIR_NONE;
            MOVE: begin
                ldx_d = 4'd2;
                ldy_d = 4'd2;
                case (cur_q)
                    DIR_LEFT: begin
                        ldx_d = 4'd1;
                        if (x_q >= X_LO + ST) x_d = x_q - ST;
                        else if (tunnel_row)  x_d = X_HI;
                        else begin x_d = X_LO; cur_d = DIR_NONE; end
                    end
                    DIR_RIGHT: begin
                        ldx_d = 4'd3;
                        if (x_q + ST <= X_HI) x_d = x_q + ST;
                        else if (tunnel_row)  x_d = X_LO;
                        else begin x_d = X_HI; cur_d = DIR_NONE; end
                    end
                    DIR_UP: begin
                        ldy_d = 4'd1;
                        if (y_q >= Y_LO + ST) y_d = y_q - ST;
                        else begin y_d = Y_LO; cur_d = DIR_NONE; end
                    end
                    DIR_DOWN: begin
                        ldy_d = 4'd3;
                        if (y_q + ST <= Y_HI) y_d = y_q + ST;
                        else begin y_d = Y_HI; cur_d = DIR_NONE; end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign wall_req  = req_q;
    assign wall_qx   = qx_q;
    assign wall_qy   = qy_q;
    assign BallX     = x_q;
    assign BallY     = y_q;
    assign BallS     = SZ;
    assign last_dirX = ldx_q;
    assign last_dirY = ldy_q;
    assign moving    = (cur_q != DIR_NONE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pacman_mover.sv
// tb/tb_pacman_mover.sv - randomized scoreboard bench for pacman_mover
module tb_pacman_mover;

    localparam int SIZE = 13, STEP = 1, XMIN = 7, XMAX = 396, YMIN = 7, YMAX = 440;
    localparam int TY = 253, TO = 15, PF = 8, NEVER = 99;

    logic       Clk = 1'b0, Reset = 1'b1, frame_tick = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       wall_ack = 1'b0, wall_hit = 1'b0;
    logic       wall_req, moving, overrun;
    logic [9:0] wall_qx, wall_qy, BallX, BallY, BallS;
    logic [3:0] last_dirX, last_dirY;

    pacman_mover dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
        .wall_req(wall_req), .wall_qx(wall_qx), .wall_qy(wall_qy),
        .wall_ack(wall_ack), .wall_hit(wall_hit),
        .BallX(BallX), .BallY(BallY), .BallS(BallS),
        .last_dirX(last_dirX), .last_dirY(last_dirY),
        .moving(moving), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    typedef struct { int x; int y; int mv; int ldx; int ldy; } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0;
    bit mon_en = 1'b0, resp_en = 1'b1;

    // reference state: directions 0 none, 1 left, 2 right, 3 up, 4 down
    int m_x, m_y, m_cur, m_pend, m_age, m_ldx, m_ldy;

    int n_probes = 0, pidx = 0, wcnt = 0;
    int p_qx[2], p_qy[2], p_lat[2], p_hit[2];

    logic [7:0] keys[5] = '{8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_x = 202; m_y = 253; m_cur = 0; m_pend = 0; m_age = 0; m_ldx = 0; m_ldy = 0;
    endtask

    task automatic model_move();
        int edge_pos;
        case (m_cur)
            1: begin
                m_ldx = 1; m_ldy = 2; edge_pos = m_x - SIZE - STEP;
                if (edge_pos >= XMIN) m_x = m_x - STEP;
                else if (m_y == TY) m_x = XMAX - SIZE;
                else begin m_x = XMIN + SIZE; m_cur = 0; end
            end
            2: begin
                m_ldx = 3; m_ldy = 2; edge_pos = m_x + SIZE + STEP;
                if (edge_pos <= XMAX) m_x = m_x + STEP;
                else if (m_y == TY) m_x = XMIN + SIZE;
                else begin m_x = XMAX - SIZE; m_cur = 0; end
            end
            3: begin
                m_ldx = 2; m_ldy = 1; edge_pos = m_y - SIZE - STEP;
                if (edge_pos >= YMIN) m_y = m_y - STEP;
                else begin m_y = YMIN + SIZE; m_cur = 0; end
            end
            4: begin
                m_ldx = 2; m_ldy = 3; edge_pos = m_y + SIZE + STEP;
                if (edge_pos <= YMAX) m_y = m_y + STEP;
                else begin m_y = YMAX - SIZE; m_cur = 0; end
            end
            default: ;
        endcase
    endtask

    task automatic add_probe(input int d, input int lat, input int hit);
        p_qx[n_probes] = m_x + ((d == 1) ? -(SIZE + STEP) : (d == 2) ? (SIZE + STEP) : 0);
        p_qy[n_probes] = m_y + ((d == 3) ? -(SIZE + STEP) : (d == 4) ? (SIZE + STEP) : 0);
        p_lat[n_probes] = lat;
        p_hit[n_probes] = hit;
        n_probes++;
    endtask

    // one frame: predict probes and outcome, then issue the tick; entered and left at posedge+1
    task automatic do_frame(input int lat0, input int hit0, input int lat1, input int hit1);
        int  p;
        bit  blocked;
        n_probes = 0; pidx = 0; wcnt = 0;
        p = m_pend;
        if (m_age > 0) begin
            m_age--;
            if (m_age == 0) m_pend = 0;
        end
        if (p != 0 && p != m_cur) begin
            add_probe(p, lat0, hit0);
            blocked = (lat0 == NEVER) || (hit0 != 0);
            if (!blocked) begin
                m_cur = p; m_pend = 0; m_age = 0; model_move();
            end else if (m_cur != 0) begin
                add_probe(m_cur, lat1, hit1);
                if ((lat1 == NEVER) || (hit1 != 0)) m_cur = 0;
                else model_move();
            end
        end else if (m_cur != 0) begin
            add_probe(m_cur, lat0, hit0);
            if ((lat0 == NEVER) || (hit0 != 0)) m_cur = 0;
            else model_move();
        end
        sb.push_back('{m_x, m_y, int'(m_cur != 0), m_ldx, m_ldy});
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        repeat (38) @(posedge Clk);
        #1;
    endtask

    task automatic apply_key(input logic [7:0] k);
        int d;
        keycode = k;
        @(posedge Clk); #1;
        keycode = 8'h00;
        @(posedge Clk); #1;
        d = (k == 8'h04) ? 1 : (k == 8'h07) ? 2 : (k == 8'h1A) ? 3 : (k == 8'h16) ? 4 : 0;
        if (d != 0) begin m_pend = d; m_age = PF; end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        model_reset();
        n_probes = 0; pidx = 0; wcnt = 0;
    endtask

    // monitor: each tick's result is compared once the slowest handshake has settled
    always begin
        @(negedge Clk);
        if (mon_en && frame_tick) begin
            exp_t e;
            repeat (36) @(negedge Clk);
            check("scoreboard_has_entry", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("BallX", BallX, e.x);
                check("BallY", BallY, e.y);
                check("moving", moving, e.mv);
                check("last_dirX", last_dirX, e.ldx);
                check("last_dirY", last_dirY, e.ldy);
                check("overrun_idle_frames", overrun, 0);
            end
        end
    end

    // wall map responder driven by the per-frame decisions
    always begin
        @(negedge Clk);
        wall_ack = 1'b0;
        wall_hit = ($urandom_range(0, 1) != 0);
        if (resp_en) begin
            if (wall_req) begin
                if (pidx >= n_probes) begin
                    check("wall_req_unexpected", wall_req, 0);
                end else begin
                    if (wcnt == 0) begin
                        check("probe_x", wall_qx, p_qx[pidx]);
                        check("probe_y", wall_qy, p_qy[pidx]);
                    end
                    if (p_lat[pidx] == NEVER) begin
                        wcnt++;
                        if (wcnt == TO) begin wcnt = 0; pidx++; end
                    end else if (wcnt == p_lat[pidx]) begin
                        wall_ack = 1'b1;
                        wall_hit = (p_hit[pidx] != 0);
                        wcnt = 0;
                        pidx++;
                    end else begin
                        wcnt++;
                    end
                end
            end else if (wcnt != 0) begin
                check("wall_req_held_until_ack", wall_req, 1);
                wcnt = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat0, lat1, hit0, hit1;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        check("reset_BallX", BallX, 202);
        check("reset_BallY", BallY, 253);
        check("reset_BallS", BallS, SIZE);
        check("reset_last_dirX", last_dirX, 0);
        check("reset_last_dirY", last_dirY, 0);
        check("reset_moving", moving, 0);
        check("reset_wall_req", wall_req, 0);
        check("reset_overrun", overrun, 0);
        mon_en = 1'b1;

        repeat (10) do_frame(0, 0, 0, 0);
        apply_key(8'h07);
        repeat (4) do_frame($urandom_range(0, 3), 0, 0, 0);
        apply_key(8'h1A);
        repeat (3) do_frame(0, 1, $urandom_range(0, 3), 0);
        do_frame(1, 0, 0, 0);
        apply_key(8'h16);
        repeat (9) do_frame(0, 1, 0, 0);

        do_reset();
        apply_key(8'h04);
        repeat (190) do_frame(0, 0, 0, 0);

        for (int f = 0; f < 120; f++) begin
            if ($urandom_range(0, 3) == 0) apply_key(keys[$urandom_range(0, 4)]);
            lat0 = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 3);
            lat1 = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 3);
            hit0 = ($urandom_range(0, 3) == 0) ? 1 : 0;
            hit1 = ($urandom_range(0, 3) == 0) ? 1 : 0;
            do_frame(lat0, hit0, lat1, hit1);
        end

        do_reset();
        apply_key(8'h07);
        do_frame(0, 0, 0, 0);
        mon_en = 1'b0;

        // Q_CUR left unanswered, with a second tick arriving mid-probe
        n_probes = 1; pidx = 0; wcnt = 0;
        p_qx[0] = 203 + SIZE + STEP; p_qy[0] = 253; p_lat[0] = NEVER; p_hit[0] = 1;
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("q_cur_wall_req", wall_req, 1);
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        check("overrun_pulse", overrun, 1);
        @(posedge Clk); #1;
        check("overrun_one_cycle", overrun, 0);
        repeat (20) @(posedge Clk);
        #1;
        check("timeout_wall_req", wall_req, 0);
        check("timeout_moving", moving, 0);
        check("timeout_BallX", BallX, 203);

        // reset in the middle of a handshake
        apply_key(8'h04);
        n_probes = 1; pidx = 0; wcnt = 0;
        p_qx[0] = 203 - SIZE - STEP; p_qy[0] = 253; p_lat[0] = NEVER; p_hit[0] = 1;
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("q_pend_wall_req", wall_req, 1);
        resp_en = 1'b0;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check("midreset_wall_req", wall_req, 0);
        check("midreset_BallX", BallX, 202);
        check("midreset_BallY", BallY, 253);
        check("midreset_moving", moving, 0);
        check("midreset_last_dirX", last_dirX, 0);
        check("midreset_last_dirY", last_dirY, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
